// File: rtl/fifo_sync_mc_if.sv
// Push/pop/status bundle for fifo_sync_mc; the DUT side uses the slave modport.
interface fifo_sync_mc_if #(
  parameter int W = 32,
  parameter int C = 4
);
  localparam int CW = $clog2(C);

  logic          push;
  logic [CW-1:0] push_chan;
  logic [W-1:0]  push_data;
  logic          pop;
  logic [CW-1:0] pop_chan;
  logic [W-1:0]  pop_data;
  logic          pop_data_vld_r;
  logic [CW-1:0] pop_chan_r;
  logic [C-1:0]  empty_r;
  logic [C-1:0]  full_r;
  logic [C-1:0]  almost_full_r;
  logic [C-1:0]  ovf_r;
  logic [C-1:0]  udf_r;

  modport master (
    output push, push_chan, push_data, pop, pop_chan,
    input  pop_data, pop_data_vld_r, pop_chan_r,
    input  empty_r, full_r, almost_full_r, ovf_r, udf_r
  );

  modport slave (
    input  push, push_chan, push_data, pop, pop_chan,
    output pop_data, pop_data_vld_r, pop_chan_r,
    output empty_r, full_r, almost_full_r, ovf_r, udf_r
  );
endinterface

// File: rtl/fifo_sync_mc.sv
// Single-clock multi-channel FIFO: C queues of depth N share one C*N x W array.
// Define FIFO_SYNC_MC_ERR_EN to build sticky overflow/underflow flags.
module fifo_sync_mc #(
  parameter int W      = 32,
  parameter int N      = 16,
  parameter int C      = 4,
  parameter int AF_LVL = 14
) (
  input  logic          clk,
  input  logic          rst,
  fifo_sync_mc_if.slave bus
);
  localparam int AW = $clog2(N);
  localparam int CW = $clog2(C);
  localparam int PW = AW + 1;
  localparam int MW = CW + AW;

  typedef logic [PW-1:0] ptr_t;

  ptr_t wptr_q [C];
  ptr_t wptr_d [C];
  ptr_t rptr_q [C];
  ptr_t rptr_d [C];
  ptr_t cnt_q  [C];
  ptr_t cnt_d  [C];

  logic [C-1:0] empty_q, empty_d;
  logic [C-1:0] full_q,  full_d;
  logic [C-1:0] af_q,    af_d;
  logic [C-1:0] push_hit, pop_hit;

  logic [W-1:0]  mem [C*N];
  logic          push_ok, pop_ok;
  logic [MW-1:0] waddr, raddr;

  logic [W-1:0]  pop_data_q;
  logic          pop_vld_q;
  logic [CW-1:0] pop_chan_q;

  // Acceptance is judged on the registered (pre-edge) flags only.
  assign push_ok = bus.push && !full_q[bus.push_chan];
  assign pop_ok  = bus.pop  && !empty_q[bus.pop_chan];
  assign waddr   = {bus.push_chan, wptr_q[bus.push_chan][AW-1:0]};
  assign raddr   = {bus.pop_chan,  rptr_q[bus.pop_chan][AW-1:0]};

  always_comb begin
    push_hit = '0;
    pop_hit  = '0;
    for (int c = 0; c < C; c++) begin
      push_hit[c] = push_ok && (bus.push_chan == CW'(c));
      pop_hit[c]  = pop_ok  && (bus.pop_chan  == CW'(c));
    end
  end

  // NOTE: combinational next-state uses blocking '=' with every output defaulted
  // first, so no latch can be inferred; the registers below use '<=' only.
  always_comb begin
    for (int c = 0; c < C; c++) begin
      wptr_d[c] = wptr_q[c];
      rptr_d[c] = rptr_q[c];
      cnt_d[c]  = cnt_q[c];
      if (push_hit[c]) wptr_d[c] = wptr_q[c] + PW'(1);
      if (pop_hit[c])  rptr_d[c] = rptr_q[c] + PW'(1);
      if (push_hit[c] && !pop_hit[c])      cnt_d[c] = cnt_q[c] + PW'(1);
      else if (!push_hit[c] && pop_hit[c]) cnt_d[c] = cnt_q[c] - PW'(1);
      empty_d[c] = (cnt_d[c] == '0);
      full_d[c]  = (cnt_d[c] == PW'(N));
      af_d[c]    = (cnt_d[c] >= PW'(AF_LVL));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < C; c++) begin
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
        cnt_q[c]  <= '0;
      end
      empty_q <= '1;
      full_q  <= '0;
      af_q    <= '0;
    end else begin
      for (int c = 0; c < C; c++) begin
        wptr_q[c] <= wptr_d[c];
        rptr_q[c] <= rptr_d[c];
        cnt_q[c]  <= cnt_d[c];
      end
      empty_q <= empty_d;
      full_q  <= full_d;
      af_q    <= af_d;
    end
  end

  // NOTE: the storage array has no reset; the flags guarantee only written
  // entries are ever read, and leaving it unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[waddr] <= bus.push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pop_data_q <= '0;
      pop_vld_q  <= 1'b0;
      pop_chan_q <= '0;
    end else begin
      pop_vld_q <= pop_ok;
      if (pop_ok) begin
        pop_data_q <= mem[raddr];
        pop_chan_q <= bus.pop_chan;
      end
    end
  end

  assign bus.pop_data       = pop_data_q;
  assign bus.pop_data_vld_r = pop_vld_q;
  assign bus.pop_chan_r     = pop_chan_q;
  assign bus.empty_r        = empty_q;
  assign bus.full_r         = full_q;
  assign bus.almost_full_r  = af_q;

`ifdef FIFO_SYNC_MC_ERR_EN
  logic [C-1:0] ovf_q, udf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= '0;
      udf_q <= '0;
    end else begin
      if (bus.push && full_q[bus.push_chan])  ovf_q[bus.push_chan] <= 1'b1;
      if (bus.pop  && empty_q[bus.pop_chan])  udf_q[bus.pop_chan]  <= 1'b1;
    end
  end

  assign bus.ovf_r = ovf_q;
  assign bus.udf_r = udf_q;
`else
  assign bus.ovf_r = '0;
  assign bus.udf_r = '0;
`endif

  // Pointer-derived full must agree with the occupancy counter.
  for (genvar g = 0; g < C; g++) begin : g_chk
    a_full_consistent: assert property (@(posedge clk) disable iff (rst)
      (((wptr_q[g][AW] != rptr_q[g][AW]) &&
        (wptr_q[g][AW-1:0] == rptr_q[g][AW-1:0])) == (cnt_q[g] == PW'(N))));
  end

  a_data_known: assert property (@(posedge clk) disable iff (rst)
    pop_vld_q |-> !$isunknown(pop_data_q));

endmodule

// File: tb/tb_fifo_sync_mc.sv
// Randomised and directed bench for fifo_sync_mc against a per-channel queue model.
module tb_fifo_sync_mc;
  localparam int W  = 32;
  localparam int N  = 16;
  localparam int C  = 4;
  localparam int AF = 14;
`ifdef FIFO_SYNC_MC_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_sync_mc_if #(.W(W), .C(C)) bus ();

  fifo_sync_mc #(.W(W), .N(N), .C(C), .AF_LVL(AF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mq [C][$];
  logic [W-1:0] exp_data;
  logic         exp_vld;
  int           exp_chan;
  logic [C-1:0] exp_ovf, exp_udf;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < C; c++) mq[c].delete();
    exp_data = '0;
    exp_vld  = 1'b0;
    exp_chan = 0;
    exp_ovf  = '0;
    exp_udf  = '0;
  endtask

  task automatic compare();
    logic [C-1:0] e_empty, e_full, e_af;
    for (int c = 0; c < C; c++) begin
      e_empty[c] = (mq[c].size() == 0);
      e_full[c]  = (mq[c].size() == N);
      e_af[c]    = (mq[c].size() >= AF);
    end
    check("vld",   64'(bus.pop_data_vld_r), 64'(exp_vld));
    check("data",  64'(bus.pop_data),       64'(exp_data));
    if (exp_vld) check("chan", 64'(bus.pop_chan_r), 64'(exp_chan));
    check("empty", 64'(bus.empty_r),        64'(e_empty));
    check("full",  64'(bus.full_r),         64'(e_full));
    check("afull", 64'(bus.almost_full_r),  64'(e_af));
    check("ovf",   64'(bus.ovf_r),          64'(exp_ovf));
    check("udf",   64'(bus.udf_r),          64'(exp_udf));
  endtask

  // One clock: drive, let the edge pass, update the model, compare.
  task automatic step(input logic ph, input int pc, input logic [W-1:0] pd,
                      input logic po, input int oc);
    bit push_acc, pop_acc;
    bus.push      = ph;
    bus.push_chan = 2'(pc);
    bus.push_data = pd;
    bus.pop       = po;
    bus.pop_chan  = 2'(oc);
    push_acc = ph && (mq[pc].size() < N);
    pop_acc  = po && (mq[oc].size() > 0);
    @(posedge clk);
    #1;
    if (ERR_EN && ph && !push_acc) exp_ovf[pc] = 1'b1;
    if (ERR_EN && po && !pop_acc)  exp_udf[oc] = 1'b1;
    exp_vld = pop_acc;
    if (pop_acc) begin
      exp_data = mq[oc].pop_front();
      exp_chan = oc;
    end
    if (push_acc) mq[pc].push_back(pd);
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    compare();
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare();
    check("rst_chan", 64'(bus.pop_chan_r), 64'd0);
    @(posedge clk);
    #3 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.push = 1'b0; bus.push_chan = '0; bus.push_data = '0;
    bus.pop  = 1'b0; bus.pop_chan  = '0;
    model_reset();
    #12 rst = 1'b0;
    @(posedge clk); #1;
    compare();
    step(0, 0, 0, 0, 0);

    // Fill channel 2 then drain it in order.
    for (int i = 0; i < 16; i++) step(1, 2, 32'hA0 + 32'(i), 0, 0);
    step(1, 2, 32'hBAD, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 2);
    step(0, 0, 0, 0, 0);

    // Interleave channels 0 and 3.
    step(1, 0, 32'h11, 0, 0);
    step(1, 3, 32'h22, 0, 0);
    step(0, 0, 0, 1, 3);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);

    // Push to full ch1 with same-channel pop.
    for (int i = 0; i < 16; i++) step(1, 1, 32'h100 + 32'(i), 0, 0);
    step(1, 1, 32'hDEAD, 1, 1);
    check("ch1_cnt15", 64'(mq[1].size()), 64'd15);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 1);

    // Pop empty ch0 with simultaneous push.
    step(1, 0, 32'h55, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);

    // Async reset mid-operation.
    for (int i = 0; i < 3; i++) step(1, 2, 32'hC0 + 32'(i), 0, 0);
    step(0, 0, 0, 1, 2);
    do_reset();
    step(1, 2, 32'h77, 0, 0);
    step(0, 0, 0, 1, 2);
    step(0, 0, 0, 0, 0);

    // Wrap ch3 across two pointer wraps at low occupancy.
    step(1, 3, 32'h300, 0, 0);
    step(1, 3, 32'h301, 0, 0);
    for (int i = 0; i < 40; i++) step(1, 3, 32'h302 + 32'(i), 1, 3);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 3);

    // Random traffic with occasional reset.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      step($urandom_range(0, 99) < 55, int'($urandom_range(0, C-1)), $urandom,
           $urandom_range(0, 99) < 50, int'($urandom_range(0, C-1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
